// File: rtl/decade_2421_counter.sv
// decade_2421_counter: mod-10 counter held and output in 2421 (Aiken) code with Mealy carry
//   clk   in   rising-edge clock
//   reset in   synchronous active-high reset, priority over x
//   x     in   count enable
//   res   out  [3:0] registered count in 2421 code
//   z     out  carry, high while count is 9 and x=1 (and reset=0)
module decade_2421_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    output logic [3:0] res,
    output logic       z
);
    logic [3:0] r_state;
    logic [3:0] w_succ;
    logic       w_legal;
    logic [3:0] w_next;
    always_comb begin
        w_succ  = 4'b0000;
        w_legal = 1'b1;
        case (r_state)
            4'b0000: w_succ = 4'b0001;
            4'b0001: w_succ = 4'b0010;
            4'b0010: w_succ = 4'b0011;
            4'b0011: w_succ = 4'b0100;
            4'b0100: w_succ = 4'b1011;
            4'b1011: w_succ = 4'b1100;
            4'b1100: w_succ = 4'b1101;
            4'b1101: w_succ = 4'b1110;
            4'b1110: w_succ = 4'b1111;
            4'b1111: w_succ = 4'b0000;
            default: w_legal = 1'b0;
        endcase
    end
    // illegal codes recover to 0 on the next edge whatever x is
    assign w_next = !w_legal ? 4'b0000 : (x ? w_succ : r_state);
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= 4'b0000;
        else
            r_state <= w_next;
    end
    assign res = r_state;
    assign z   = ~reset & x & (r_state == 4'b1111);
endmodule

// File: tb/tb_decade_2421_counter.sv
// tb_decade_2421_counter: directed self-checking bench for decade_2421_counter
module tb_decade_2421_counter;
    logic       clk;
    logic       reset;
    logic       x;
    logic [3:0] res;
    logic       z;
    int         n_pass;
    int         n_total;

    decade_2421_counter dut (
        .clk  (clk),
        .reset(reset),
        .x    (x),
        .res  (res),
        .z    (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        x     = 1'b1;
        #1;
        n_total++;
        if (z !== 1'b0) $display("FAIL reset_z_pre got=%b exp=0", z); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step();
            n_total++;
            if (res !== 4'b0000) $display("FAIL reset_res[%0d] got=%b exp=0000", i, res); else n_pass++;
            n_total++;
            if (z !== 1'b0) $display("FAIL reset_z[%0d] got=%b exp=0", i, z); else n_pass++;
        end
    endtask

    task automatic test_full_cycle();
        logic [3:0] exp_seq [10];
        logic [3:0] prev;
        exp_seq = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1011,
                    4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0000};
        reset = 1'b0;
        x     = 1'b1;
        prev  = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_total++;
            if (z !== (prev == 4'b1111)) $display("FAIL cycle_z[%0d] got=%b exp=%b", i, z, prev == 4'b1111); else n_pass++;
            step();
            n_total++;
            if (res !== exp_seq[i]) $display("FAIL cycle_res[%0d] got=%b exp=%b", i, res, exp_seq[i]); else n_pass++;
            prev = exp_seq[i];
        end
    endtask

    task automatic test_hold();
        x = 1'b1;
        for (int i = 0; i < 4; i++) step();
        n_total++;
        if (res !== 4'b0100) $display("FAIL hold_setup got=%b exp=0100", res); else n_pass++;
        x = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (res !== 4'b0100 || z !== 1'b0) $display("FAIL hold_4[%0d] got=%b/%b exp=0100/0", i, res, z); else n_pass++;
        end
        x = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_total++;
        if (res !== 4'b1111) $display("FAIL hold_to9 got=%b exp=1111", res); else n_pass++;
        x = 1'b0;
        #1;
        n_total++;
        if (z !== 1'b0) $display("FAIL hold9_z got=%b exp=0", z); else n_pass++;
        step();
        n_total++;
        if (res !== 4'b1111) $display("FAIL hold9_res got=%b exp=1111", res); else n_pass++;
        x = 1'b1;
        #1;
        n_total++;
        if (z !== 1'b1) $display("FAIL wrap_z got=%b exp=1", z); else n_pass++;
        step();
        n_total++;
        if (res !== 4'b0000) $display("FAIL wrap_res got=%b exp=0000", res); else n_pass++;
    endtask

    task automatic test_alternating();
        logic [3:0] exp_seq [8];
        exp_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                    4'b0011, 4'b0011, 4'b0100, 4'b0100};
        for (int i = 0; i < 8; i++) begin
            x = (i % 2 == 0);
            step();
            n_total++;
            if (res !== exp_seq[i]) $display("FAIL alt_res[%0d] got=%b exp=%b", i, res, exp_seq[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        x = 1'b1;
        for (int i = 0; i < 4; i++) step();
        n_total++;
        if (res !== 4'b1110) $display("FAIL mid_setup got=%b exp=1110", res); else n_pass++;
        reset = 1'b1;
        step();
        n_total++;
        if (res !== 4'b0000) $display("FAIL mid_reset got=%b exp=0000", res); else n_pass++;
        reset = 1'b0;
        step();
        n_total++;
        if (res !== 4'b0001) $display("FAIL mid_resume got=%b exp=0001", res); else n_pass++;
        for (int i = 0; i < 8; i++) step();
        n_total++;
        if (res !== 4'b1111 || z !== 1'b1) $display("FAIL pend_setup got=%b/%b exp=1111/1", res, z); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (z !== 1'b0) $display("FAIL pend_z_drop got=%b exp=0", z); else n_pass++;
        step();
        n_total++;
        if (res !== 4'b0000 || z !== 1'b0) $display("FAIL pend_reset got=%b/%b exp=0000/0", res, z); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 2; k++) begin
            force dut.r_state = 4'b0110;
            #1;
            release dut.r_state;
            x = 1'b1;
            #1;
            n_total++;
            if (res !== 4'b0110 || z !== 1'b0) $display("FAIL illegal_z[%0d] got=%b/%b exp=0110/0", k, res, z); else n_pass++;
            x = (k == 1);
            step();
            n_total++;
            if (res !== 4'b0000) $display("FAIL illegal_rec[%0d] got=%b exp=0000", k, res); else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        x       = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_cycle();
        test_hold();
        test_alternating();
        test_reset_mid();
        test_illegal();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
